// File: rtl/global_defs.sv
// rtl/global_defs.sv - project-wide default sizes for the MPU datapath
package global_defs;
    localparam int FP               = 32;
    localparam int M                = 3;
    localparam int N                = 3;
    localparam int MATRIX_REGISTERS = 16;
endpackage

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - MPU shared types, load command record and helpers
package mpu_pkg;
    import global_defs::*;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } mpu_operation_t;

    typedef enum logic {
        LOAD_IDLE   = 1'b0,
        LOAD_MATRIX = 1'b1
    } load_state_t;

    localparam int LOAD_ADDR_W       = $clog2(MATRIX_REGISTERS);
    localparam int LOAD_M_W          = $clog2(M) + 1;
    localparam int LOAD_N_W          = $clog2(N) + 1;
    localparam int LOAD_MAX_ELEMENTS = M * N;

    typedef struct packed {
        logic [LOAD_ADDR_W-1:0] dest;
        logic [LOAD_M_W-1:0]    m;
        logic [LOAD_N_W-1:0]    n;
    } load_cmd_t;

    // A dimension is usable only when it names at least one and at most max_dim rows/cols.
    function automatic logic dim_in_range(input int unsigned dim, input int unsigned max_dim);
        return (dim != 0) && (dim <= max_dim);
    endfunction
endpackage

// File: rtl/mpu_load_if.sv
// rtl/mpu_load_if.sv - command, element stream, write port and completion bundle of the load unit
interface mpu_load_if
    import mpu_pkg::*;
#(
    parameter int FP               = global_defs::FP,
    parameter int M                = global_defs::M,
    parameter int N                = global_defs::N,
    parameter int MATRIX_REGISTERS = global_defs::MATRIX_REGISTERS
) ();
    localparam int A_W = $clog2(MATRIX_REGISTERS);

    mpu_operation_t      mpu_op_in;
    logic [A_W-1:0]      dest_in;
    logic [$clog2(M):0]  m_in;
    logic [$clog2(N):0]  n_in;
    logic                load_ready_out;

    logic [FP-1:0]       element_in;
    logic                element_valid_in;
    logic                element_ready_out;

    logic                reg_wr_en_out;
    logic [A_W-1:0]      reg_wr_addr_out;
    logic [$clog2(M)-1:0] reg_wr_row_out;
    logic [$clog2(N)-1:0] reg_wr_col_out;
    logic [FP-1:0]       reg_wr_data_out;

    logic                load_done_out;
    logic [$clog2(M):0]  load_m_out;
    logic [$clog2(N):0]  load_n_out;
    logic                load_error_out;

    modport slave (
        input  mpu_op_in, dest_in, m_in, n_in, element_in, element_valid_in,
        output load_ready_out, element_ready_out,
        output reg_wr_en_out, reg_wr_addr_out, reg_wr_row_out, reg_wr_col_out, reg_wr_data_out,
        output load_done_out, load_m_out, load_n_out, load_error_out
    );

    modport master (
        output mpu_op_in, dest_in, m_in, n_in, element_in, element_valid_in,
        input  load_ready_out, element_ready_out,
        input  reg_wr_en_out, reg_wr_addr_out, reg_wr_row_out, reg_wr_col_out, reg_wr_data_out,
        input  load_done_out, load_m_out, load_n_out, load_error_out
    );
endinterface

// File: rtl/mpu_index_counter.sv
// rtl/mpu_index_counter.sv - row-major row/col walker with runtime limits and last-element flag
module mpu_index_counter #(
    parameter int  ROW_W = 2,
    parameter int  COL_W = 2,
    localparam int MW    = ROW_W + 1,
    localparam int NW    = COL_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [MW-1:0]    i_m_limit,
    input  logic [NW-1:0]    i_n_limit,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_row_end;
    logic             w_col_end;

    assign w_row_end = (MW'(r_row) == (i_m_limit - MW'(1)));
    assign w_col_end = (NW'(r_col) == (i_n_limit - NW'(1)));

    // Wrapping the row on the last element leaves the walker at (0,0) for the next user.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_row_end && w_col_end;
endmodule

// File: rtl/mpu_load.sv
// rtl/mpu_load.sv - matrix LOAD front-end: command latch, element stream, register-file writes
module mpu_load
    import mpu_pkg::*;
#(
    parameter int FP               = global_defs::FP,
    parameter int M                = global_defs::M,
    parameter int N                = global_defs::N,
    parameter int MATRIX_REGISTERS = global_defs::MATRIX_REGISTERS
) (
    input logic       clk,
    input logic       rst,
    mpu_load_if.slave bus
);
    localparam int A_W = $clog2(MATRIX_REGISTERS);
    localparam int R_W = $clog2(M);
    localparam int C_W = $clog2(N);

    load_state_t     r_state;
    load_state_t     w_next_state;
    load_cmd_t       r_cmd;

    logic            w_accept;
    logic            w_dims_ok;
    logic            w_xfer;
    logic            w_last;
    logic [R_W-1:0]  w_row;
    logic [C_W-1:0]  w_col;

    logic            r_wr_en;
    logic [A_W-1:0]  r_wr_addr;
    logic [R_W-1:0]  r_wr_row;
    logic [C_W-1:0]  r_wr_col;
    logic [FP-1:0]   r_wr_data;
    logic            r_done;
    logic [R_W:0]    r_done_m;
    logic [C_W:0]    r_done_n;
    logic            r_error;

    assign w_accept  = (r_state == LOAD_IDLE) && (bus.mpu_op_in == LOAD);
    assign w_dims_ok = dim_in_range(32'(bus.m_in), M) && dim_in_range(32'(bus.n_in), N);
    assign w_xfer    = (r_state == LOAD_MATRIX) && bus.element_valid_in;

    mpu_index_counter #(
        .ROW_W (R_W),
        .COL_W (C_W)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_advance (w_xfer),
        .i_m_limit (r_cmd.m),
        .i_n_limit (r_cmd.n),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD_IDLE: begin
                if (w_accept && w_dims_ok) begin
                    w_next_state = LOAD_MATRIX;
                end
            end
            LOAD_MATRIX: begin
                if (w_xfer && w_last) begin
                    w_next_state = LOAD_IDLE;
                end
            end
            default: w_next_state = LOAD_IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready_out    = (r_state == LOAD_IDLE);
        bus.element_ready_out = (r_state == LOAD_MATRIX);
    end

    // Rejected commands leave the previous command intact; it is never reused without a new accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (w_accept && w_dims_ok) begin
            r_cmd.dest <= bus.dest_in;
            r_cmd.m    <= bus.m_in;
            r_cmd.n    <= bus.n_in;
        end
    end

    // Done and dimensions ride on the same edge as the final write so the register file sees them together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_done_m  <= '0;
            r_done_n  <= '0;
            r_error   <= 1'b0;
        end else begin
            r_wr_en   <= w_xfer;
            r_wr_addr <= w_xfer ? r_cmd.dest : '0;
            r_wr_row  <= w_xfer ? w_row : '0;
            r_wr_col  <= w_xfer ? w_col : '0;
            r_wr_data <= w_xfer ? bus.element_in : '0;
            r_done    <= w_xfer && w_last;
            r_done_m  <= (w_xfer && w_last) ? r_cmd.m : '0;
            r_done_n  <= (w_xfer && w_last) ? r_cmd.n : '0;
            r_error   <= w_accept && !w_dims_ok;
        end
    end

    assign bus.reg_wr_en_out   = r_wr_en;
    assign bus.reg_wr_addr_out = r_wr_addr;
    assign bus.reg_wr_row_out  = r_wr_row;
    assign bus.reg_wr_col_out  = r_wr_col;
    assign bus.reg_wr_data_out = r_wr_data;
    assign bus.load_done_out   = r_done;
    assign bus.load_m_out      = r_done_m;
    assign bus.load_n_out      = r_done_n;
    assign bus.load_error_out  = r_error;
endmodule
